// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module  : fetch_stage_if
// Purpose : Instruction-memory, redirect and IF/ID handshake bundle for fetch_stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_stage_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output if_valid,
        output if_instr,
        output if_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  halted
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Purpose : PC owner and one-entry fetch slot feeding IF/ID; optional HALT
//           support is compiled in with `define FETCH_HALT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fetch_stage_if.master     bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

`ifdef FETCH_HALT_EN
    localparam logic c_HALT_EN = 1'b1;
`else
    localparam logic c_HALT_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ifpc_q, ifpc_d;

    logic        w_transfer;
    logic        w_slot_free;
    logic        w_halt_hit;

    assign w_transfer  = valid_q && bus.id_ready;
    assign w_slot_free = !valid_q || bus.id_ready;
    // With the feature compiled out the halt opcode is an ordinary instruction.
    assign w_halt_hit  = c_HALT_EN && (bus.imem_data == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 16'h0000;
            ifpc_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;

        if (bus.redirect_valid) begin
            // Wrong-path slot is discarded; a same-edge transfer still completes.
            pc_d    = bus.redirect_pc;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (state_q == ST_HALT) begin
            if (w_transfer) begin
                valid_d = 1'b0;
            end
        end else if (w_slot_free) begin
            instr_d = bus.imem_data;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            if (w_halt_hit) begin
                state_d = ST_HALT;
            end else begin
                pc_d = pc_q + 16'h0001;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ifpc_q;
    assign bus.halted    = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Purpose : Directed self-checking bench for fetch_stage with a transfer scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] sb_q[$];

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC    (16'h0010),
        .HALT_OPCODE (16'hFFFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Asynchronous-read memory: mem[a] = a + 0x1000, except a halt word at 0x0005.
    assign bus.imem_data = (bus.imem_addr == 16'h0005) ? 16'hFFFF
                                                       : (bus.imem_addr + 16'h1000);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [15:0] instr);
        sb_q.push_back({pc, instr});
    endtask

    // Scores any transfer that will happen on the coming edge, then advances one cycle.
    task automatic tick();
        logic [31:0] e;
        if (bus.if_valid === 1'b1 && bus.id_ready === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed pc=%h expected no transfer", bus.if_pc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_pc", bus.if_pc, e[31:16]);
                chk("sb_instr", bus.if_instr, e[15:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.id_ready       = 1'b0;
        #1;
        chk("rst_addr", bus.imem_addr, 16'h0010);
        chk("rst_valid", {15'd0, bus.if_valid}, 16'h0000);
        chk("rst_instr", bus.if_instr, 16'h0000);
        chk("rst_pc", bus.if_pc, 16'h0000);
        chk("rst_halted", {15'd0, bus.halted}, 16'h0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rel_addr", bus.imem_addr, 16'h0010);

        // Streaming from reset.
        bus.id_ready = 1'b1;
        push(16'h0010, 16'h1010);
        push(16'h0011, 16'h1011);
        tick();
        chk("s0_valid", {15'd0, bus.if_valid}, 16'h0001);
        chk("s0_pc", bus.if_pc, 16'h0010);
        chk("s0_instr", bus.if_instr, 16'h1010);
        chk("s0_addr", bus.imem_addr, 16'h0011);
        tick();
        chk("s1_pc", bus.if_pc, 16'h0011);
        chk("s1_addr", bus.imem_addr, 16'h0012);

        // Back-pressure for three cycles.
        bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", bus.if_pc, 16'h0011);
            chk("stall_instr", bus.if_instr, 16'h1011);
            chk("stall_addr", bus.imem_addr, 16'h0012);
        end
        bus.id_ready = 1'b1;
        push(16'h0012, 16'h1012);
        tick();
        chk("resume_pc", bus.if_pc, 16'h0012);
        chk("resume_addr", bus.imem_addr, 16'h0013);
        tick();
        chk("s3_pc", bus.if_pc, 16'h0013);

        // Redirect during a stall drops the held 0x0013.
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_valid", {15'd0, bus.if_valid}, 16'h0000);
        chk("redir_addr", bus.imem_addr, 16'h0040);
        tick();
        chk("redir_pc", bus.if_pc, 16'h0040);
        chk("redir_instr", bus.if_instr, 16'h1040);
        bus.id_ready = 1'b1;
        push(16'h0040, 16'h1040);
        push(16'h0041, 16'h1041);
        tick();
        chk("post_redir_pc", bus.if_pc, 16'h0041);

        // Redirect with a same-edge transfer, landing near the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFE;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wrap_valid0", {15'd0, bus.if_valid}, 16'h0000);
        chk("wrap_addr0", bus.imem_addr, 16'hFFFE);
        push(16'hFFFE, 16'h0FFE);
        push(16'hFFFF, 16'h0FFF);
        push(16'h0000, 16'h1000);
        tick();
        chk("wrap_pcFE", bus.if_pc, 16'hFFFE);
        tick();
        chk("wrap_pcFF", bus.if_pc, 16'hFFFF);
        chk("wrap_addr", bus.imem_addr, 16'h0000);
        tick();
        chk("wrap_pc00", bus.if_pc, 16'h0000);
        chk("wrap_instr", bus.if_instr, 16'h1000);
        chk("wrap_valid", {15'd0, bus.if_valid}, 16'h0001);

        // Fetch the 0xFFFF word at 0x0005.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0004;
        tick();
        bus.redirect_valid = 1'b0;
        chk("h_addr4", bus.imem_addr, 16'h0004);
        push(16'h0004, 16'h1004);
        push(16'h0005, 16'hFFFF);
        tick();
        chk("h_pc4", bus.if_pc, 16'h0004);
        tick();
        chk("h_pc5", bus.if_pc, 16'h0005);
        chk("h_instr5", bus.if_instr, 16'hFFFF);
        chk("h_valid5", {15'd0, bus.if_valid}, 16'h0001);
`ifdef FETCH_HALT_EN
        chk("h_halted", {15'd0, bus.halted}, 16'h0001);
        chk("h_addr_hold", bus.imem_addr, 16'h0005);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("h_drained", {15'd0, bus.if_valid}, 16'h0000);
            chk("h_addr_stay", bus.imem_addr, 16'h0005);
            chk("h_still", {15'd0, bus.halted}, 16'h0001);
            tick();
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0020;
        tick();
        bus.redirect_valid = 1'b0;
        chk("h_exit", {15'd0, bus.halted}, 16'h0000);
        chk("h_exit_addr", bus.imem_addr, 16'h0020);
        tick();
        chk("h_resume_pc", bus.if_pc, 16'h0020);
        chk("h_resume_instr", bus.if_instr, 16'h1020);
`else
        chk("nh_halted", {15'd0, bus.halted}, 16'h0000);
        chk("nh_addr", bus.imem_addr, 16'h0006);
        tick();
        chk("nh_pc6", bus.if_pc, 16'h0006);
        chk("nh_instr6", bus.if_instr, 16'h1006);
`endif

        // Asynchronous reset in the middle of a stalled cycle.
        bus.id_ready = 1'b0;
        tick();
        chk("pre_rst_valid", {15'd0, bus.if_valid}, 16'h0001);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {15'd0, bus.if_valid}, 16'h0000);
        chk("arst_halted", {15'd0, bus.halted}, 16'h0000);
        chk("arst_addr", bus.imem_addr, 16'h0010);
        chk("arst_pc", bus.if_pc, 16'h0000);
        chk("sb_drained", 16'(sb_q.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
